// File: rtl/ps2_key_event_queue_if.sv
// Key-event pop interface between the PS/2 front end and its consumer.
//   evt_valid  : head entry present (driven by the queue)
//   evt_ready  : consumer takes the head entry this cycle
//   evt_code   : head scan code
//   evt_ext    : head event carried the 0xE0 prefix
//   evt_break  : head event is a release
// master = the queue, slave = the consumer.
interface ps2_key_event_queue_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;

  modport master (
    output evt_valid, evt_code, evt_ext, evt_break,
    input  evt_ready
  );

  modport slave (
    input  evt_valid, evt_code, evt_ext, evt_break,
    output evt_ready
  );
endinterface

// File: rtl/ps2_key_event_queue.sv
// PS/2 keyboard front end: synchronises the raw PS/2 pins, deframes 11-bit
// device-to-host frames, decodes E0/F0 prefixed scan codes into key events,
// tracks modifier keys, filters typematic repeats and queues events in a FIFO.
// Ports:
//   clk, clrn         system clock, async active-low reset
//   ps2_clk, ps2_data raw PS/2 pins (asynchronous)
//   en                1 = queue decoded events, 0 = drop them
//   evt               pop interface (valid/ready + registered head entry)
//   evt_count         FIFO occupancy
//   mods              {ralt, lalt, rctrl, lctrl, rshift, lshift}
//   cur_key           last queued event {16'h0, E0?, F0?, code}
//   overflow, ovf_clr sticky drop flag and its clear
//   frame_err         one-cycle pulse per discarded frame
//
// Receiver FSM
//   state   | meaning
//   RX_IDLE | waiting for a start bit (data low on a clock fall)
//   RX_RECV | collecting data, parity and stop bits; timeout armed
// Decoder FSM
//   state    | meaning
//   DEC_IDLE | no prefix pending
//   DEC_E0   | 0xE0 seen
//   DEC_F0   | 0xF0 seen
//   DEC_E0F0 | 0xE0 0xF0 seen
module ps2_key_event_queue #(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FILTER_REPEAT  = 1
) (
  input  logic                          clk,
  input  logic                          clrn,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          en,
  ps2_key_event_queue_if.master         evt,
  output logic [$clog2(FIFO_DEPTH):0]   evt_count,
  output logic [5:0]                    mods,
  output logic [31:0]                   cur_key,
  output logic                          overflow,
  input  logic                          ovf_clr,
  output logic                          frame_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;
  typedef enum logic [1:0] {DEC_IDLE, DEC_E0, DEC_F0, DEC_E0F0} dec_state_t;

  // ---------------- synchroniser and edge detect ----------------
  logic [SYNC_STAGES-1:0] ps2c_sync_q, ps2d_sync_q;
  logic                   ps2c_prev_q;
  logic                   ps2c_s, ps2d_s, fall;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ps2c_sync_q <= '1;
      ps2d_sync_q <= '1;
      ps2c_prev_q <= 1'b1;
    end else begin
      ps2c_sync_q <= {ps2c_sync_q[SYNC_STAGES-2:0], ps2_clk};
      ps2d_sync_q <= {ps2d_sync_q[SYNC_STAGES-2:0], ps2_data};
      ps2c_prev_q <= ps2c_s;
    end
  end

  assign ps2c_s = ps2c_sync_q[SYNC_STAGES-1];
  assign ps2d_s = ps2d_sync_q[SYNC_STAGES-1];
  assign fall   = ps2c_prev_q & ~ps2c_s;

  // ---------------- receiver ----------------
  rx_state_t  rx_q, rx_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [8:0] shift_q, shift_d;      // {parity, data[7:0]} once complete
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic       byte_vld_q, byte_vld_d;
  logic [7:0] byte_q, byte_d;
  logic       ferr_q, ferr_d;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      rx_q       <= RX_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tmo_q      <= '0;
      byte_vld_q <= 1'b0;
      byte_q     <= '0;
      ferr_q     <= 1'b0;
    end else begin
      rx_q       <= rx_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tmo_q      <= tmo_d;
      byte_vld_q <= byte_vld_d;
      byte_q     <= byte_d;
      ferr_q     <= ferr_d;
    end
  end

  always_comb begin
    rx_d       = rx_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tmo_d      = tmo_q;
    byte_vld_d = 1'b0;
    byte_d     = byte_q;
    ferr_d     = 1'b0;
    case (rx_q)
      RX_IDLE: begin
        if (fall && !ps2d_s) begin
          rx_d      = RX_RECV;
          bit_cnt_d = '0;
          tmo_d     = TMO_W'(TIMEOUT_CYCLES - 1);
        end
      end
      RX_RECV: begin
        if (fall) begin
          tmo_d = TMO_W'(TIMEOUT_CYCLES - 1);
          if (bit_cnt_q == 4'd9) begin
            // Stop edge: odd parity means the 9 collected bits XOR to 1.
            rx_d = RX_IDLE;
            if ((^shift_q) && ps2d_s) begin
              byte_vld_d = 1'b1;
              byte_d     = shift_q[7:0];
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            shift_d   = {ps2d_s, shift_q[8:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else if (tmo_q == '0) begin
          rx_d   = RX_IDLE;
          ferr_d = 1'b1;
        end else begin
          tmo_d = tmo_q - TMO_W'(1);
        end
      end
      default: rx_d = RX_IDLE;
    endcase
  end

  assign frame_err = ferr_q;

  // ---------------- decoder ----------------
  dec_state_t dec_q, dec_d;
  logic       emit, ev_ext, ev_brk;
  logic       non_key;

  assign non_key = (byte_q == 8'h00) || (byte_q == 8'hAA) || (byte_q == 8'hEE) ||
                   (byte_q == 8'hFA) || (byte_q == 8'hFE) || (byte_q == 8'hFF);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) dec_q <= DEC_IDLE;
    else       dec_q <= dec_d;
  end

  always_comb begin
    dec_d  = dec_q;
    emit   = 1'b0;
    ev_ext = 1'b0;
    ev_brk = 1'b0;
    if (ferr_q) begin
      dec_d = DEC_IDLE;
    end else if (byte_vld_q) begin
      if (non_key) begin
        dec_d = DEC_IDLE;
      end else if (dec_q == DEC_IDLE && byte_q == 8'hE0) begin
        dec_d = DEC_E0;
      end else if (dec_q == DEC_IDLE && byte_q == 8'hF0) begin
        dec_d = DEC_F0;
      end else if (dec_q == DEC_E0 && byte_q == 8'hF0) begin
        dec_d = DEC_E0F0;
      end else if (dec_q == DEC_E0 && byte_q == 8'hE0) begin
        dec_d = DEC_E0;
      end else begin
        emit   = 1'b1;
        ev_ext = (dec_q == DEC_E0) || (dec_q == DEC_E0F0);
        ev_brk = (dec_q == DEC_F0) || (dec_q == DEC_E0F0);
        dec_d  = DEC_IDLE;
      end
    end
  end

  // ---------------- modifiers and repeat filter ----------------
  logic [5:0] mods_q, mods_d;
  logic       lm_vld_q, lm_vld_d, lm_ext_q, lm_ext_d;
  logic [7:0] lm_code_q, lm_code_d;
  logic       suppress;

  assign suppress = (FILTER_REPEAT != 0) && emit && !ev_brk && lm_vld_q &&
                    (lm_ext_q == ev_ext) && (lm_code_q == byte_q);

  always_comb begin
    mods_d    = mods_q;
    lm_vld_d  = lm_vld_q;
    lm_ext_d  = lm_ext_q;
    lm_code_d = lm_code_q;
    if (emit) begin
      case ({ev_ext, byte_q})
        9'h012: mods_d[0] = !ev_brk;
        9'h059: mods_d[1] = !ev_brk;
        9'h014: mods_d[2] = !ev_brk;
        9'h114: mods_d[3] = !ev_brk;
        9'h011: mods_d[4] = !ev_brk;
        9'h111: mods_d[5] = !ev_brk;
        default: ;
      endcase
      // Any release ends a typematic run, so the filter forgets its key.
      if (ev_brk) begin
        lm_vld_d = 1'b0;
      end else if (!suppress) begin
        lm_vld_d  = 1'b1;
        lm_ext_d  = ev_ext;
        lm_code_d = byte_q;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      mods_q    <= '0;
      lm_vld_q  <= 1'b0;
      lm_ext_q  <= 1'b0;
      lm_code_q <= '0;
    end else begin
      mods_q    <= mods_d;
      lm_vld_q  <= lm_vld_d;
      lm_ext_q  <= lm_ext_d;
      lm_code_q <= lm_code_d;
    end
  end

  assign mods = mods_q;

  // ---------------- event FIFO ----------------
  logic [9:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_nxt;
  logic [CNT_W-1:0] count_q, count_d;
  logic [9:0]       head_q, head_d, push_word;
  logic             push_req, push_ok, pop, full;
  logic             ovf_q, ovf_d;
  logic [31:0]      key_q, key_d;

  assign full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop       = (count_q != '0) && evt.evt_ready;
  assign push_req  = emit && !suppress && en;
  assign push_ok   = push_req && (!full || pop);
  assign push_word = {ev_ext, ev_brk, byte_q};
  assign rd_nxt    = rd_ptr_q + PTR_W'(1);
  assign count_d   = count_q + CNT_W'(push_ok) - CNT_W'(pop);

  // The head register is loaded ahead of time so the consumer always sees
  // a registered entry; an empty FIFO takes the pushed word directly.
  always_comb begin
    head_d = head_q;
    if (pop) begin
      if (count_q > CNT_W'(1)) head_d = mem_q[rd_nxt];
      else if (push_ok)        head_d = push_word;
    end else if (push_ok && count_q == '0) begin
      head_d = push_word;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr)                  ovf_d = 1'b0;
    if (push_req && full && !pop) ovf_d = 1'b1;
  end

  always_comb begin
    key_d = key_q;
    if (push_ok) key_d = {16'h0, ev_ext ? 8'hE0 : 8'h00, ev_brk ? 8'hF0 : 8'h00, byte_q};
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_word;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      ovf_q    <= 1'b0;
      key_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_nxt;
      count_q <= count_d;
      head_q  <= head_d;
      ovf_q   <= ovf_d;
      key_q   <= key_d;
    end
  end

  assign evt.evt_valid = (count_q != '0);
  assign evt.evt_ext   = head_q[9];
  assign evt.evt_break = head_q[8];
  assign evt.evt_code  = head_q[7:0];
  assign evt_count     = count_q;
  assign overflow      = ovf_q;
  assign cur_key       = key_q;

endmodule

// File: tb/tb_ps2_key_event_queue.sv
module tb_ps2_key_event_queue;

  localparam int DEPTH = 4;
  localparam int TMO   = 300;
  localparam int HALF  = 10;

  typedef struct {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } evt_t;

  typedef struct {
    logic [7:0] b;
    bit         bad;
    bit         evt;
    bit         ext;
    bit         brk;
    logic [5:0] mods;
  } vec_t;

  logic clk = 1'b0;
  logic clrn, ps2_clk, ps2_data, en, ovf_clr;
  logic [$clog2(DEPTH):0] evt_count;
  logic [5:0]  mods;
  logic [31:0] cur_key;
  logic overflow, frame_err;

  ps2_key_event_queue_if evt_if();

  ps2_key_event_queue #(
    .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TMO), .FILTER_REPEAT(1)
  ) dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .en(en),
    .evt(evt_if), .evt_count(evt_count), .mods(mods), .cur_key(cur_key),
    .overflow(overflow), .ovf_clr(ovf_clr), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   fails  = 0;
  int   fe_cnt = 0;
  evt_t sb[$];
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard consumer and frame_err pulse counter.
  always @(negedge clk) begin
    if (clrn && frame_err) fe_cnt++;
    if (clrn && evt_if.evt_valid && evt_if.evt_ready) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_event: got code %h ext %0d brk %0d expected none",
                 evt_if.evt_code, evt_if.evt_ext, evt_if.evt_break);
      end else begin
        evt_t e;
        e = sb.pop_front();
        check("evt_code", {24'h0, evt_if.evt_code}, {24'h0, e.code});
        check("evt_ext", {31'h0, evt_if.evt_ext}, {31'h0, e.ext});
        check("evt_break", {31'h0, evt_if.evt_break}, {31'h0, e.brk});
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      cyc(HALF);
      ps2_clk = 1'b0;
      cyc(HALF);
      ps2_clk = 1'b1;
    end
    cyc(HALF);
    ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad);
    logic par;
    par = bad ? (^b) : ~(^b);
    send_bits({1'b1, par, b, 1'b0}, 11);
    cyc(40);
  endtask

  task automatic expect_evt(input logic ext, input logic brk, input logic [7:0] code);
    evt_t e;
    e.ext = ext; e.brk = brk; e.code = code;
    sb.push_back(e);
  endtask

  task automatic add(input logic [7:0] b, input bit bad, input bit ev,
                     input bit ext, input bit brk, input logic [5:0] m);
    vec_t v;
    v.b = b; v.bad = bad; v.evt = ev; v.ext = ext; v.brk = brk; v.mods = m;
    vecs.push_back(v);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      cyc(1);
      n++;
    end
    check(name, sb.size(), 0);
  endtask

  initial begin
    logic [31:0] key_model;
    int          n_bad, fe0;
    vec_t        v;

    clrn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; en = 1'b1; ovf_clr = 1'b0;
    evt_if.evt_ready = 1'b1;

    add(8'h1C,0,1,0,0,6'h00); add(8'hF0,0,0,0,0,6'h00); add(8'h1C,0,1,0,1,6'h00);
    add(8'hE0,0,0,0,0,6'h00); add(8'h75,0,1,1,0,6'h00);
    add(8'hE0,0,0,0,0,6'h00); add(8'hF0,0,0,0,0,6'h00); add(8'h75,0,1,1,1,6'h00);
    add(8'h12,0,1,0,0,6'h01);
    for (int i = 0; i < 4; i++) add(8'h12,0,0,0,0,6'h01);
    add(8'hF0,0,0,0,0,6'h01); add(8'h12,0,1,0,1,6'h00);
    add(8'hE0,0,0,0,0,6'h00); add(8'h14,0,1,1,0,6'h08);
    add(8'hE0,0,0,0,0,6'h08); add(8'hF0,0,0,0,0,6'h08); add(8'h14,0,1,1,1,6'h00);
    add(8'h11,0,1,0,0,6'h10); add(8'h59,0,1,0,0,6'h12);
    add(8'hF0,0,0,0,0,6'h12); add(8'h59,0,1,0,1,6'h10);
    add(8'hF0,0,0,0,0,6'h10); add(8'h11,0,1,0,1,6'h00);
    add(8'hAA,0,0,0,0,6'h00);
    add(8'hE0,0,0,0,0,6'h00); add(8'hFA,0,0,0,0,6'h00); add(8'h1C,0,1,0,0,6'h00);
    add(8'hF0,0,0,0,0,6'h00); add(8'h55,1,0,0,0,6'h00); add(8'h2A,0,1,0,0,6'h00);
    add(8'hE1,0,1,0,0,6'h00);

    cyc(5);
    check("rst_evt_valid", {31'h0, evt_if.evt_valid}, 0);
    check("rst_evt_count", {29'h0, evt_count}, 0);
    check("rst_evt_code", {24'h0, evt_if.evt_code}, 0);
    check("rst_mods", {26'h0, mods}, 0);
    check("rst_cur_key", cur_key, 0);
    check("rst_overflow", {31'h0, overflow}, 0);
    check("rst_frame_err", {31'h0, frame_err}, 0);
    clrn = 1'b1;
    cyc(10);

    key_model = 32'h0;
    n_bad = 0;
    fe0 = fe_cnt;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (v.evt) begin
        expect_evt(v.ext, v.brk, v.b);
        key_model = {16'h0, v.ext ? 8'hE0 : 8'h00, v.brk ? 8'hF0 : 8'h00, v.b};
      end
      if (v.bad) n_bad++;
      send_byte(v.b, v.bad);
      check($sformatf("mods_row%0d", i), {26'h0, mods}, {26'h0, v.mods});
      check($sformatf("cur_key_row%0d", i), cur_key, key_model);
    end
    check("table_frame_err", fe_cnt - fe0, n_bad);
    wait_drain("table_drain");

    // en=0: events dropped, modifiers still tracked, cur_key held.
    en = 1'b0;
    send_byte(8'h12, 0);
    check("en0_mods", {26'h0, mods}, 32'h01);
    check("en0_count", {29'h0, evt_count}, 0);
    check("en0_cur_key", cur_key, key_model);
    send_byte(8'hF0, 0);
    send_byte(8'h12, 0);
    check("en0_mods_rel", {26'h0, mods}, 0);
    en = 1'b1;

    // FIFO fill with consumer stalled.
    evt_if.evt_ready = 1'b0;
    begin
      logic [7:0] codes [6];
      codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35};
      for (int i = 0; i < 6; i++) begin
        if (i < DEPTH) expect_evt(1'b0, 1'b0, codes[i]);
        send_byte(codes[i], 0);
      end
    end
    check("full_count", {29'h0, evt_count}, DEPTH);
    check("full_overflow", {31'h0, overflow}, 1);
    check("full_head", {24'h0, evt_if.evt_code}, 32'h15);
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    check("ovf_clr", {31'h0, overflow}, 0);
    evt_if.evt_ready = 1'b1;
    wait_drain("fifo_drain");
    cyc(2);
    check("drained_count", {29'h0, evt_count}, 0);

    // Partial frame abandoned by timeout.
    fe0 = fe_cnt;
    send_bits(11'b111_1111_0100, 4);
    cyc(TMO + 50);
    check("timeout_frame_err", fe_cnt - fe0, 1);
    check("timeout_no_evt", {31'h0, evt_if.evt_valid}, 0);
    expect_evt(1'b0, 1'b0, 8'h29);
    send_byte(8'h29, 0);
    wait_drain("timeout_next_evt");

    // Reset mid-sequence and mid-frame.
    send_byte(8'hE0, 0);
    send_bits(11'b111_1111_0110, 5);
    clrn = 1'b0;
    cyc(3);
    check("mid_rst_count", {29'h0, evt_count}, 0);
    check("mid_rst_cur_key", cur_key, 0);
    clrn = 1'b1;
    cyc(5);
    expect_evt(1'b0, 1'b0, 8'h1C);
    send_byte(8'h1C, 0);
    wait_drain("post_rst_evt");
    check("post_rst_cur_key", cur_key, 32'h0000_001C);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ps2_key_event_queue.md
# ps2_key_event_queue

Parametrised PS/2 keyboard front end: receives PS/2 device-to-host frames, checks framing and parity, and decodes make, break and extended (0xE0) scan-code sequences into key events. Events are buffered in a FIFO with a valid/ready pop interface, alongside live modifier-key state and a 32-bit last-event word. It sits between the board PS/2 pins and the CPU-side keyboard MMIO port, and replaces the single-register keyboard decoder.

## Interface
- FIFO_DEPTH, 8: event FIFO entries; must be a power of two, ≥2.
- SYNC_STAGES, 2: synchroniser flops on ps2_clk and ps2_data; ≥2.
- TIMEOUT_CYCLES, 50000: idle clk cycles after which a partial frame is abandoned.
- FILTER_REPEAT, 1: 1 = suppress typematic repeats of the same make event.
- clk  in  1  system clock, single clock domain.
- clrn  in  1  reset; asynchronous, active-low.
- ps2_clk  in  1  raw PS/2 clock pin (asynchronous).
- ps2_data  in  1  raw PS/2 data pin (asynchronous).
- en  in  1  1 = decoded events are queued; 0 = events are dropped.
- evt_ready  in  1  consumer accepts the head event this cycle.
- evt_valid  out  1  FIFO non-empty.
- evt_code  out  8  head event scan code.
- evt_ext  out  1  head event carried the 0xE0 prefix.
- evt_break  out  1  head event is a release (carried 0xF0).
- evt_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- mods  out  6  {ralt, lalt, rctrl, lctrl, rshift, lshift}; 1 = held.
- cur_key  out  32  last queued event: {16'h0, ext?8'hE0:8'h00, brk?8'hF0:8'h00, code}.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.
- ovf_clr  in  1  synchronous clear of overflow.
- frame_err  out  1  one-cycle pulse on each discarded frame.

## Operation
- Receiver: synchronise both pins, then detect falling edges of synced ps2_clk. Sample synced ps2_data on each edge into an 11-bit frame: start (0), 8 data bits LSB first, odd parity, stop (1).
  - Start bit of 1: ignore the edge and stay idle; no frame_err.
  - Parity or stop error: discard the byte, pulse frame_err, force the decoder to IDLE.
  - Timeout: once the start bit is accepted, TIMEOUT_CYCLES cycles with no falling edge abandon the frame, pulse frame_err and return to idle.
- Decoder states: IDLE, E0, F0, E0F0.
  - IDLE, byte 0xE0 -> E0. IDLE, byte 0xF0 -> F0. E0, byte 0xF0 -> E0F0. E0, byte 0xE0 -> stays in E0.
  - Any other byte emits event {ext = state∈{E0,E0F0}, brk = state∈{F0,E0F0}, code = byte} and returns to IDLE.
  - Non-key bytes 0x00, 0xAA, 0xEE, 0xFA, 0xFE, 0xFF: emit nothing, go to IDLE.
  - 0xE1 (Pause) is an ordinary code; no special handling.
- Modifiers update on every emitted event regardless of en or filtering: make sets the bit, break clears it.
  - 12 = lshift, 59 = rshift, 14 = lctrl, E0 14 = rctrl, 11 = lalt, E0 11 = ralt.
- Repeat filter (FILTER_REPEAT=1): keep a last-make register {valid, ext, code}.
  - A make event equal to it is suppressed; no other effect.
  - Any break, or any different make, updates or clears the register. A break of the registered key clears valid.
- Queue: a non-suppressed event with en=1 is pushed and copied to cur_key. With en=0 it is dropped and cur_key holds.
  - Push while full (and no pop that cycle): the event is dropped and overflow is set.
  - Pop occurs when evt_valid & evt_ready.
  - Simultaneous push and pop: both succeed, including when full; occupancy is unchanged and overflow is not set.
  - Pointers wrap modulo FIFO_DEPTH; the extra evt_count bit distinguishes full from empty.
- ovf_clr clears overflow. If an overflow occurs in the same cycle, set wins.

## Timing
- Reset values:
  - Outputs: evt_valid=0, evt_count=0, evt_code/ext/break=0, mods=0, cur_key=0, overflow=0, frame_err=0.
  - Internal: decoder IDLE, receiver idle, last-make invalid, FIFO empty.
- Cycle T is the cycle in which the stop-bit falling edge is detected after synchronisation. The decoder sees the byte at T+1; the push, cur_key and mods updates are visible at T+2.
- No fall-through: a push into an empty FIFO raises evt_valid at T+2 at the earliest.
- evt_code/ext/break are registered FIFO head outputs. They are stable while evt_valid=1 and evt_ready=0, and advance the cycle after a pop.
- frame_err is high for exactly one cycle, at the cycle following the stop-bit edge or the timeout expiry.
- Asserting clrn mid-frame or mid-sequence discards all partial state; the first frame after release is decoded from IDLE.

## Test plan
- Frame 0x1C, then F0 1C -> two events {00,0,1C} and {00,1,1C}. cur_key ends at 32'h0000_F01C.
- E0 75, then E0 F0 75 -> events ext=1 make, then ext=1 break. cur_key=32'h00E0_F075. mods unchanged.
- 0x12 repeated 5 times, then F0 12, FILTER_REPEAT=1 -> exactly 2 events. mods[0] is 1 between them, then 0.
- FIFO_DEPTH=4, evt_ready=0, 6 makes of distinct codes -> evt_count=4, overflow=1, first 4 codes retained in order. ovf_clr clears overflow.
- Frame with bad parity, then F0 and 0x2A -> frame_err pulses once. Emits make of 0x2A only if the bad frame followed the F0; decoder forced to IDLE.
- Partial frame of 4 bits, then TIMEOUT_CYCLES idle, then a valid 0x29 -> one frame_err pulse, then event 0x29.
